player_motion: RTL and testbench



---
 rtl/finalsoc_pkg.sv | 37 +++
 rtl/player_motion_if.sv | 21 ++
 rtl/key_decoder.sv | 27 ++
 rtl/player_motion.sv | 174 +++++++++++++++++
 tb/tb_player_motion.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/finalsoc_pkg.sv
// Shared definitions for the finalsoc player logic: HID key codes, field widths,
// the kinematics FSM encoding and helpers for the {hi16, lo16} PIO word layout.
package finalsoc_pkg;

    localparam int POS_W = 16;

    // USB HID usage codes
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_UP    = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_VEL,
        ST_POS,
        ST_PUBLISH
    } state_t;

    function automatic logic [2*POS_W-1:0] pack_hl(input logic [POS_W-1:0] hi,
                                                   input logic [POS_W-1:0] lo);
        return {hi, lo};
    endfunction

    function automatic logic [POS_W-1:0] hi_half(input logic [2*POS_W-1:0] w);
        return w[2*POS_W-1:POS_W];
    endfunction

    function automatic logic [POS_W-1:0] lo_half(input logic [2*POS_W-1:0] w);
        return w[POS_W-1:0];
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Frame/keyboard inputs and published kinematics outputs of one player_motion instance.
// master drives ticks and keys (SoC side), slave is the motion block.
interface player_motion_if;
    logic        frame_tick;
    logic        respawn;
    logic [15:0] keycode;
    logic [31:0] pos_export;
    logic [31:0] vel_export;
    logic        on_ground;
    logic        busy;

    modport master (
        output frame_tick, respawn, keycode,
        input  pos_export, vel_export, on_ground, busy
    );

    modport slave (
        input  frame_tick, respawn, keycode,
        output pos_export, vel_export, on_ground, busy
    );
endinterface

// File: rtl/key_decoder.sv
// Matches both keycode bytes against the left/right/up codes; purely combinational.
// A zero byte means "no key" and never matches, even if a code parameter is zero.
module key_decoder
    import finalsoc_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT  = HID_A,
    parameter logic [7:0] KEY_RIGHT = HID_D,
    parameter logic [7:0] KEY_UP    = HID_W
) (
    input  logic [15:0] keycode,
    output logic        left,
    output logic        right,
    output logic        up
);

    function automatic logic hit(input logic [15:0] kc, input logic [7:0] code);
        return ((kc[7:0]  != 8'h00) && (kc[7:0]  == code)) ||
               ((kc[15:8] != 8'h00) && (kc[15:8] == code));
    endfunction

    always_comb begin
        left  = hit(keycode, KEY_LEFT);
        right = hit(keycode, KEY_RIGHT);
        up    = hit(keycode, KEY_UP);
    end

endmodule

// File: rtl/player_motion.sv
// Per-player kinematics: once per frame samples keys, updates velocity then position,
// and publishes pos/vel/on_ground together 4 cycles after frame_tick; ticks while busy are dropped.
module player_motion
    import finalsoc_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT   = HID_A,
    parameter logic [7:0] KEY_RIGHT  = HID_D,
    parameter logic [7:0] KEY_UP     = HID_W,
    parameter int         SPAWN_X    = 100,
    parameter int         SPAWN_Y    = 400,
    parameter int         X_MIN      = 0,
    parameter int         X_MAX      = 620,
    parameter int         Y_MIN      = 0,
    parameter int         GROUND_Y   = 400,
    parameter int         WALK_SPEED = 3,
    parameter int         GRAVITY    = 1,
    parameter int         JUMP_SPEED = 12,
    parameter int         MAX_FALL   = 10
) (
    input  logic           clk_50_clk,
    input  logic           reset_50_reset_n,
    player_motion_if.slave pm
);

    localparam logic [POS_W-1:0]  SPAWN_X_V = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0]  SPAWN_Y_V = POS_W'(SPAWN_Y);
    localparam logic [POS_W-1:0]  WALK_P    = POS_W'(WALK_SPEED);
    localparam logic [POS_W-1:0]  WALK_N    = POS_W'(-WALK_SPEED);
    localparam logic [POS_W-1:0]  JUMP_N    = POS_W'(-JUMP_SPEED);
    localparam logic [POS_W-1:0]  MAXF_V    = POS_W'(MAX_FALL);
    localparam logic signed [POS_W:0] GRAV_S = (POS_W+1)'(GRAVITY);
    localparam logic signed [POS_W:0] MAXF_S = (POS_W+1)'(MAX_FALL);
    localparam logic signed [POS_W:0] XMIN_S = (POS_W+1)'(X_MIN);
    localparam logic signed [POS_W:0] XMAX_S = (POS_W+1)'(X_MAX);
    localparam logic signed [POS_W:0] YMIN_S = (POS_W+1)'(Y_MIN);
    localparam logic signed [POS_W:0] GND_S  = (POS_W+1)'(GROUND_Y);

    state_t state, state_nxt;
    logic   do_sample, do_vel, do_pos, do_pub;

    logic key_l, key_r, key_u;
    logic left_q, right_q, jump_q, prev_up_q;

    // Working registers; only copied to the outputs in PUBLISH
    logic [POS_W-1:0] x_q, y_q, vx_q, vy_q;
    logic             ground_q;

    logic [2*POS_W-1:0] pos_q, vel_q;
    logic               on_ground_q;

    logic [POS_W-1:0]        vx_cmd, vy_vel, x_pos, y_pos, vy_pos;
    logic                    ground_vel, ground_pos;
    logic signed [POS_W:0]   vy_inc, nx_s, ny_s;

    key_decoder #(
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .KEY_UP    (KEY_UP)
    ) u_keys (
        .keycode (pm.keycode),
        .left    (key_l),
        .right   (key_r),
        .up      (key_u)
    );

    always_ff @(posedge clk_50_clk) begin
        if (!reset_50_reset_n) state <= ST_IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (pm.frame_tick) state_nxt = ST_SAMPLE;
            ST_SAMPLE:  state_nxt = ST_VEL;
            ST_VEL:     state_nxt = ST_POS;
            ST_POS:     state_nxt = ST_PUBLISH;
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (pm.respawn) state_nxt = ST_IDLE;
    end

    always_comb begin
        do_sample = (state == ST_SAMPLE);
        do_vel    = (state == ST_VEL);
        do_pos    = (state == ST_POS);
        do_pub    = (state == ST_PUBLISH);
        pm.busy   = (state != ST_IDLE);
    end

    always_comb begin
        vx_cmd = '0;
        if (right_q && !left_q)      vx_cmd = WALK_P;
        else if (left_q && !right_q) vx_cmd = WALK_N;

        vy_inc     = $signed({vy_q[POS_W-1], vy_q}) + GRAV_S;
        vy_vel     = '0;
        ground_vel = ground_q;
        if (ground_q && jump_q) begin
            vy_vel     = JUMP_N;
            ground_vel = 1'b0;
        end else if (!ground_q) begin
            vy_vel = (vy_inc > MAXF_S) ? MAXF_V : vy_inc[POS_W-1:0];
        end
    end

    // 17-bit signed sums so a step past either edge is visible before clamping
    always_comb begin
        nx_s = $signed({1'b0, x_q}) + $signed({vx_q[POS_W-1], vx_q});
        ny_s = $signed({1'b0, y_q}) + $signed({vy_q[POS_W-1], vy_q});

        if (nx_s < XMIN_S)      x_pos = POS_W'(X_MIN);
        else if (nx_s > XMAX_S) x_pos = POS_W'(X_MAX);
        else                    x_pos = nx_s[POS_W-1:0];

        y_pos      = ny_s[POS_W-1:0];
        vy_pos     = vy_q;
        ground_pos = ground_q;
        if (ny_s >= GND_S) begin
            y_pos      = POS_W'(GROUND_Y);
            vy_pos     = '0;
            ground_pos = 1'b1;
        end else if (ny_s < YMIN_S) begin
            y_pos  = POS_W'(Y_MIN);
            vy_pos = '0;
        end
    end

    always_ff @(posedge clk_50_clk) begin
        if (!reset_50_reset_n || pm.respawn) begin
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            jump_q      <= 1'b0;
            prev_up_q   <= 1'b0;
            x_q         <= SPAWN_X_V;
            y_q         <= SPAWN_Y_V;
            vx_q        <= '0;
            vy_q        <= '0;
            ground_q    <= 1'b1;
            pos_q       <= pack_hl(SPAWN_X_V, SPAWN_Y_V);
            vel_q       <= '0;
            on_ground_q <= 1'b1;
        end else begin
            if (do_sample) begin
                left_q    <= key_l;
                right_q   <= key_r;
                jump_q    <= key_u & ~prev_up_q;
                prev_up_q <= key_u;
            end
            if (do_vel) begin
                vx_q     <= vx_cmd;
                vy_q     <= vy_vel;
                ground_q <= ground_vel;
            end
            if (do_pos) begin
                x_q      <= x_pos;
                y_q      <= y_pos;
                vy_q     <= vy_pos;
                ground_q <= ground_pos;
            end
            if (do_pub) begin
                pos_q       <= pack_hl(x_q, y_q);
                vel_q       <= pack_hl(vx_q, vy_q);
                on_ground_q <= ground_q;
            end
        end
    end

    assign pm.pos_export = pos_q;
    assign pm.vel_export = vel_q;
    assign pm.on_ground  = on_ground_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: table of single-frame vectors plus hand-written
// sequences for jump/landing, left clamp, respawn priority and ticks while busy.
module tb_player_motion;
    import finalsoc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    player_motion_if bus();

    player_motion dut (
        .clk_50_clk       (clk),
        .reset_50_reset_n (rst_n),
        .pm               (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit torn  = 1'b0;

    typedef struct {
        logic [15:0] kc;
        logic [31:0] pos;
        logic [31:0] vel;
        logic        gnd;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pos,
                               input logic [31:0] vel, input logic gnd);
        chk({tag, "_pos"}, bus.pos_export, pos);
        chk({tag, "_vel"}, bus.vel_export, vel);
        chk({tag, "_gnd"}, {31'b0, bus.on_ground}, {31'b0, gnd});
    endtask

    // One-cycle tick with keycode held; returns on the negedge after busy drops
    task automatic run_frame(input logic [15:0] kc, input logic watch,
                             input logic [31:0] old_pos, output int cyc);
        @(negedge clk);
        bus.keycode    = kc;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 10) begin
            if (watch && bus.pos_export !== old_pos) torn = 1'b1;
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] prev_pos;
        logic [15:0] ex;
        int          xi;

        vecs[0] = '{16'h0007, 32'h0067_0190, 32'h0003_0000, 1'b1};
        vecs[1] = '{16'h0704, 32'h0067_0190, 32'h0000_0000, 1'b1};
        vecs[2] = '{16'h001A, 32'h0067_0184, 32'h0000_FFF4, 1'b0};
        vecs[3] = '{16'h001A, 32'h0067_0179, 32'h0000_FFF5, 1'b0};

        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.respawn    = 1'b0;
        bus.keycode    = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_state("reset", 32'h0064_0190, 32'h0, 1'b1);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);

        prev_pos = 32'h0064_0190;
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].kc, 1'b1, prev_pos, cyc);
            chk($sformatf("vec%0d_busy_cycles", i), cyc, 32'd4);
            check_state($sformatf("vec%0d", i), vecs[i].pos, vecs[i].vel, vecs[i].gnd);
            prev_pos = vecs[i].pos;
        end

        // Up held: rise, apex, saturated fall, landing on tick 26, no re-jump on 27
        for (int t = 3; t <= 27; t++) begin
            run_frame(16'h001A, 1'b0, 32'h0, cyc);
            chk($sformatf("jump%0d_y_le_ground", t),
                {31'b0, (bus.pos_export[15:0] <= 16'd400)}, 32'd1);
            chk($sformatf("jump%0d_vy_le_max", t),
                {31'b0, ($signed(bus.vel_export[15:0]) <= 16'sd10)}, 32'd1);
            if (t == 23) check_state("jump23", 32'h0067_0179, 32'h0000_000A, 1'b0);
            if (t == 26) check_state("land26", 32'h0067_0190, 32'h0000_0000, 1'b1);
            if (t == 27) check_state("held27", 32'h0067_0190, 32'h0000_0000, 1'b1);
        end

        @(negedge clk);
        bus.respawn = 1'b1;
        @(negedge clk);
        bus.respawn = 1'b0;
        check_state("respawn", 32'h0064_0190, 32'h0, 1'b1);
        chk("respawn_busy", {31'b0, bus.busy}, 32'd0);

        // Walk left into the x = 0 clamp
        prev_pos = 32'h0064_0190;
        for (int t = 1; t <= 35; t++) begin
            xi = 100 - 3 * t;
            ex = (xi < 0) ? 16'd0 : 16'(xi);
            run_frame(16'h0004, 1'b1, prev_pos, cyc);
            if (t >= 33) check_state($sformatf("left%0d", t), {ex, 16'd400}, 32'hFFFD_0000, 1'b1);
            prev_pos = {ex, 16'd400};
        end

        run_frame(16'h001A, 1'b1, prev_pos, cyc);
        check_state("air", 32'h0000_0184, 32'h0000_FFF4, 1'b0);

        // respawn and frame_tick together: respawn wins, no frame runs
        @(negedge clk);
        bus.respawn    = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.respawn    = 1'b0;
        bus.frame_tick = 1'b0;
        check_state("resp_tick", 32'h0064_0190, 32'h0, 1'b1);
        chk("resp_tick_busy", {31'b0, bus.busy}, 32'd0);
        repeat (6) @(negedge clk);
        check_state("resp_tick_late", 32'h0064_0190, 32'h0, 1'b1);

        // Second tick during busy is dropped
        bus.keycode    = 16'h0007;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (8) @(negedge clk);
        check_state("busy_tick", 32'h0067_0190, 32'h0003_0000, 1'b1);
        chk("busy_tick_idle", {31'b0, bus.busy}, 32'd0);

        // respawn mid-frame discards the frame in flight
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        bus.respawn = 1'b1;
        @(negedge clk);
        bus.respawn = 1'b0;
        repeat (6) @(negedge clk);
        check_state("mid_respawn", 32'h0064_0190, 32'h0, 1'b1);

        chk("no_early_update", {31'b0, torn}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
